fetch_queue_stage: RTL and testbench

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

---
 rtl/fetch_queue_stage.sv | 194 +++++++++++++++++++
 tb/tb_fetch_queue_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: a single-line buffer in front of the memory bus and an
// in-order queue toward decode. Fetching stops after a control-flow instruction until a retarget arrives.
module fetch_queue_stage #(
    parameter int CORE_ID = 0,
    parameter int ADDR_W  = 64,
    parameter int LINE_W  = 64,
    parameter int INSN_W  = 32,
    parameter int MASK_W  = 64,
    parameter int QDEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [15:0]       mem_req_bus_id,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    input  logic              redir_valid,
    output logic              redir_ready,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [MASK_W-1:0] redir_mask,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [INSN_W-1:0] dec_insn,
    output logic [MASK_W-1:0] dec_mask,
    output logic [31:0]       wait_cycles,
    output logic              fetch_err
);

    localparam int LB   = LINE_W / 8;
    localparam int IB   = INSN_W / 8;
    localparam int IPL  = LINE_W / INSN_W;
    localparam int IB_W = $clog2(IB);
    localparam int QAW  = $clog2(QDEPTH);

    localparam logic [3:0] COMPONENT_TYPE_FETCH = 4'h1;

    localparam logic [7:0] OP_HALT              = 8'h3F;
    localparam logic [7:0] OP_JMP_ALWAYS        = 8'h20;
    localparam logic [7:0] OP_JMP_EQUAL         = 8'h21;
    localparam logic [7:0] OP_JMP_NOT_EQUAL     = 8'h22;
    localparam logic [7:0] OP_JMP_GREATER       = 8'h23;
    localparam logic [7:0] OP_JMP_GREATER_EQUAL = 8'h24;
    localparam logic [7:0] OP_JMP_LOWER         = 8'h25;
    localparam logic [7:0] OP_JMP_LOWER_EQUAL   = 8'h26;
    localparam logic [7:0] OP_LOAD_RESTORE_PC   = 8'h30;

    typedef enum logic [2:0] {
        S_FETCH,
        S_REQ,
        S_WAIT_RSP,
        S_WAIT_REDIR,
        S_ERROR
    } state_t;

    function automatic logic is_ctrl_flow(input logic [7:0] op);
        return op inside {OP_HALT, OP_JMP_ALWAYS, OP_JMP_EQUAL, OP_JMP_NOT_EQUAL,
                          OP_JMP_GREATER, OP_JMP_GREATER_EQUAL, OP_JMP_LOWER,
                          OP_JMP_LOWER_EQUAL, OP_LOAD_RESTORE_PC};
    endfunction

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [MASK_W-1:0] exec_mask;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] line_data;
    logic              line_valid;

    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [INSN_W-1:0] q_insn [QDEPTH];
    logic [MASK_W-1:0] q_mask [QDEPTH];
    logic [QAW:0]      wr_ptr;
    logic [QAW:0]      rd_ptr;

    logic [ADDR_W-1:0] pc_line;
    logic [ADDR_W-1:0] slot_sel;
    logic [INSN_W-1:0] cur_insn;
    logic              misaligned;
    logic              hit;
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic              pop;

    assign pc_line    = fetch_pc & ~ADDR_W'(LB - 1);
    assign slot_sel   = (fetch_pc & ADDR_W'(LB - 1)) >> IB_W;
    assign misaligned = (fetch_pc & ADDR_W'(IB - 1)) != '0;
    assign hit        = line_valid && (line_addr == pc_line);

    always_comb begin
        // NOTE: default first so every path assigns cur_insn and no latch is inferred.
        cur_insn = '0;
        for (int i = 0; i < IPL; i++) begin
            if (slot_sel == ADDR_W'(i)) cur_insn = line_data[i*INSN_W +: INSN_W];
        end
    end

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[QAW] != rd_ptr[QAW]) && (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
    assign pop     = !q_empty && dec_ready;
    // A pop in the same cycle makes room, so a full queue still accepts a push then.
    assign push    = (state == S_FETCH) && !misaligned && hit && (!q_full || pop);

    assign dec_valid      = !q_empty;
    assign dec_pc         = q_pc[rd_ptr[QAW-1:0]];
    assign dec_insn       = q_insn[rd_ptr[QAW-1:0]];
    assign dec_mask       = q_mask[rd_ptr[QAW-1:0]];
    assign mem_req_addr   = req_addr;
    assign mem_req_bus_id = {12'(CORE_ID), COMPONENT_TYPE_FETCH};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_FETCH;
            fetch_pc      <= '0;
            exec_mask     <= '1;
            req_addr      <= '0;
            line_addr     <= '0;
            line_data     <= '0;
            line_valid    <= 1'b0;
            mem_req_valid <= 1'b0;
            redir_ready   <= 1'b0;
            wait_cycles   <= '0;
            fetch_err     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (misaligned) begin
                        fetch_err <= 1'b1;
                        state     <= S_ERROR;
                    end else if (!hit) begin
                        req_addr      <= pc_line;
                        mem_req_valid <= 1'b1;
                        state         <= S_REQ;
                    end else if (push) begin
                        fetch_pc <= fetch_pc + ADDR_W'(IB);
                        if (is_ctrl_flow(cur_insn[7:0])) begin
                            redir_ready <= 1'b1;
                            state       <= S_WAIT_REDIR;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        line_addr  <= req_addr;
                        line_data  <= mem_rsp_data;
                        line_valid <= 1'b1;
                        state      <= S_FETCH;
                    end else if (wait_cycles != '1) begin
                        wait_cycles <= wait_cycles + 32'd1;
                    end
                end
                S_WAIT_REDIR: begin
                    if (redir_valid) begin
                        fetch_pc    <= redir_pc;
                        exec_mask   <= redir_mask;
                        redir_ready <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                S_ERROR: ;
                default: state <= S_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (QAW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (QAW+1)'(1);
        end
    end

    // NOTE: queue storage has no reset; the pointers alone say which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr[QAW-1:0]]   <= fetch_pc;
            q_insn[wr_ptr[QAW-1:0]] <= cur_insn;
            q_mask[wr_ptr[QAW-1:0]] <= exec_mask;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: line fills, redirects, queue back-pressure,
// wait counting, misalignment error and mid-request reset.
module tb_fetch_queue_stage;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic [15:0] mem_req_bus_id;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        redir_valid = 1'b0;
    logic        redir_ready;
    logic [63:0] redir_pc = '0;
    logic [63:0] redir_mask = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [63:0] dec_pc;
    logic [31:0] dec_insn;
    logic [63:0] dec_mask;
    logic [31:0] wait_cycles;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_queue_stage #(
        .CORE_ID(5), .ADDR_W(64), .LINE_W(64), .INSN_W(32), .MASK_W(64), .QDEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_bus_id(mem_req_bus_id),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .redir_mask(redir_mask),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_insn(dec_insn), .dec_mask(dec_mask),
        .wait_cycles(wait_cycles), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        redir_valid = 1'b0;
        dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_redir_ready", 64'(redir_ready), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_wait_cycles", 64'(wait_cycles), 64'd0);
        check("rst_fetch_err", 64'(fetch_err), 64'd0);
        reset_n = 1'b1;
    endtask

    task automatic wait_req(input logic [63:0] exp_addr);
        int n = 0;
        @(negedge clk);
        while (!mem_req_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("req_valid", 64'(mem_req_valid), 64'd1);
        check("req_addr", mem_req_addr, exp_addr);
        check("req_bus_id", 64'(mem_req_bus_id), 64'h0051);
    endtask

    // Accept the pending request, then return data after 'delay' idle cycles.
    task automatic respond(input logic [63:0] data, input int delay);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (delay) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic pop_head(input logic [63:0] pc, input logic [63:0] insn, input logic [63:0] mask);
        int n = 0;
        while (!dec_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("head_valid", 64'(dec_valid), 64'd1);
        check("head_pc", dec_pc, pc);
        check("head_insn", 64'(dec_insn), insn);
        check("head_mask", dec_mask, mask);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] pc, input logic [63:0] mask);
        int n = 0;
        while (!redir_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("redir_ready_hi", 64'(redir_ready), 64'd1);
        redir_valid = 1'b1;
        redir_pc    = pc;
        redir_mask  = mask;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Two sequential instructions from the first line, then a miss on the next line.
        do_reset();
        wait_req(64'h0);
        respond(64'h00000005_00000003, 0);
        check("lat_empty_before_push", 64'(dec_valid), 64'd0);
        @(negedge clk);
        check("lat_valid_after_push", 64'(dec_valid), 64'd1);
        pop_head(64'h0, 64'h3, ONES);
        pop_head(64'h4, 64'h5, ONES);
        check("drained", 64'(dec_valid), 64'd0);
        wait_req(64'h8);

        // Jump at PC 0 blocks fetch until the retarget to 0x40 with mask 1.
        do_reset();
        wait_req(64'h0);
        respond(64'h00000000_00000020, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("redir_ready_hold", 64'(redir_ready), 64'd1);
            check("no_req_in_redir", 64'(mem_req_valid), 64'd0);
            @(negedge clk);
        end
        pop_head(64'h0, 64'h20, ONES);
        check("only_jump_pushed", 64'(dec_valid), 64'd0);
        redirect(64'h40, 64'h1);
        check("redir_ready_lo", 64'(redir_ready), 64'd0);
        wait_req(64'h40);
        respond(64'h00000005_00000003, 0);
        pop_head(64'h40, 64'h3, 64'h1);

        // Back-pressure: four entries fill the queue, then a hit holds until a pop.
        do_reset();
        wait_req(64'h0);
        respond(64'h00000005_00000003, 0);
        wait_req(64'h8);
        respond(64'h0000000B_00000009, 0);
        wait_req(64'h10);
        respond(64'h0000000F_0000000D, 0);
        repeat (4) @(negedge clk);
        check("full_hold_no_req", 64'(mem_req_valid), 64'd0);
        check("full_hold_head", dec_pc, 64'h0);
        pop_head(64'h0, 64'h3, ONES);
        repeat (3) @(negedge clk);
        check("refill_hold_no_req", 64'(mem_req_valid), 64'd0);
        pop_head(64'h4, 64'h5, ONES);
        @(negedge clk);
        check("same_cycle_refill_req", 64'(mem_req_valid), 64'd1);
        check("same_cycle_refill_addr", mem_req_addr, 64'h18);
        pop_head(64'h8, 64'h9, ONES);
        pop_head(64'hC, 64'hB, ONES);
        pop_head(64'h10, 64'hD, ONES);
        pop_head(64'h14, 64'hF, ONES);
        check("bp_drained", 64'(dec_valid), 64'd0);

        // Slow memory: address stable while not accepted, ten wait cycles counted.
        do_reset();
        wait_req(64'h0);
        respond(64'h00000005_00000003, 0);
        wait_req(64'h8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(mem_req_valid), 64'd1);
            check("stall_addr", mem_req_addr, 64'h8);
        end
        respond(64'h00000007_00000006, 10);
        check("wait_cycles_10", 64'(wait_cycles), 64'd10);
        repeat (2) @(negedge clk);
        check("wait_cycles_kept", 64'(wait_cycles), 64'd10);

        // Misaligned retarget: sticky error, no fetch activity, queue still drains.
        do_reset();
        wait_req(64'h0);
        respond(64'h0000003F_00000003, 0);
        redirect(64'h6, 64'h3);
        repeat (2) @(negedge clk);
        check("err_set", 64'(fetch_err), 64'd1);
        check("err_no_req", 64'(mem_req_valid), 64'd0);
        check("err_redir_lo", 64'(redir_ready), 64'd0);
        pop_head(64'h0, 64'h3, ONES);
        pop_head(64'h4, 64'h3F, ONES);
        repeat (3) @(negedge clk);
        check("err_no_push", 64'(dec_valid), 64'd0);
        check("err_still_no_req", 64'(mem_req_valid), 64'd0);
        check("err_sticky", 64'(fetch_err), 64'd1);

        // Retarget inside the cached line hits; retarget near the top wraps to 0.
        do_reset();
        wait_req(64'h0);
        respond(64'h00000030_00000020, 0);
        pop_head(64'h0, 64'h20, ONES);
        redirect(64'h4, 64'h5);
        check("inline_no_req_a", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        check("inline_no_req_b", 64'(mem_req_valid), 64'd0);
        pop_head(64'h4, 64'h30, 64'h5);
        redirect(64'hFFFF_FFFF_FFFF_FFFC, 64'h2);
        wait_req(64'hFFFF_FFFF_FFFF_FFF8);
        respond(64'h00000009_00000000, 0);
        pop_head(64'hFFFF_FFFF_FFFF_FFFC, 64'h9, 64'h2);
        wait_req(64'h0);

        // Reset during WAIT_RSP; a response right after release must be ignored.
        do_reset();
        wait_req(64'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_wait", 64'(wait_cycles), 64'd2);
        reset_n = 1'b0;
        #1;
        check("async_req_valid", 64'(mem_req_valid), 64'd0);
        check("async_wait_cycles", 64'(wait_cycles), 64'd0);
        check("async_dec_valid", 64'(dec_valid), 64'd0);
        check("async_redir_ready", 64'(redir_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h00000005_00000003;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("late_rsp_no_push", 64'(dec_valid), 64'd0);
        wait_req(64'h0);
        repeat (2) @(negedge clk);
        check("late_rsp_still_empty", 64'(dec_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
